// File: rtl/accumulator_dump.sv
// accumulator_dump: parametrised integrate-and-dump accumulator.
// Windowed running sum with signed/unsigned, saturate/wrap and dump pulse.
module accumulator_dump #(
    parameter int IN_W     = 13,
    parameter int ACC_W    = 20,
    parameter bit SIGNED   = 1'b0,
    parameter bit SATURATE = 1'b1,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  A,
    input  logic [CNT_W-1:0] dump_len,
    output logic [ACC_W-1:0] Y,
    output logic [ACC_W-1:0] dump_data,
    output logic             dump_valid,
    output logic             dump_ovf,
    output logic             ovf
);

    generate
        if (ACC_W < IN_W) begin : g_width_check
            $error("accumulator_dump: ACC_W must be >= IN_W");
        end
    endgenerate

    localparam int SW = ACC_W + 1;

    localparam logic [ACC_W-1:0] S_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] S_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [ACC_W-1:0] U_MAX = {ACC_W{1'b1}};

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W-1:0] dump_data_q, dump_data_d;
    logic             dump_ovf_q, dump_ovf_d;
    logic             dump_valid_q, dump_valid_d;

    logic             a_fill;
    logic             acc_fill;
    logic [SW-1:0]    a_ext;
    logic [SW-1:0]    acc_ext;
    logic [SW-1:0]    sum;
    logic [ACC_W-1:0] res;
    logic             add_ovf;
    logic [CNT_W-1:0] len_eff;
    logic             last;

    // Extend sample and accumulator one bit past ACC_W so overflow is visible.
    always_comb begin
        a_fill   = SIGNED ? A[IN_W-1] : 1'b0;
        acc_fill = SIGNED ? acc_q[ACC_W-1] : 1'b0;
        a_ext    = {{(SW-IN_W){a_fill}}, A};
        acc_ext  = {acc_fill, acc_q};
        sum      = acc_ext + a_ext;
    end

    // Detect out-of-range sums and clamp or wrap them.
    always_comb begin
        res     = sum[ACC_W-1:0];
        add_ovf = 1'b0;
        if (SIGNED) begin
            add_ovf = sum[ACC_W] ^ sum[ACC_W-1];
            if (add_ovf && SATURATE) begin
                res = sum[ACC_W] ? S_MIN : S_MAX;
            end
        end else begin
            add_ovf = sum[ACC_W];
            if (add_ovf && SATURATE) begin
                res = U_MAX;
            end
        end
    end

    // Window length comes live from the port only on a window's first sample.
    always_comb begin
        len_eff = (cnt_q == '0) ? dump_len : len_q;
        last    = (len_eff != '0) && (cnt_q == len_eff - CNT_W'(1));
    end

    // Next-state: clr beats a sample, which beats hold; pulse defaults low.
    always_comb begin
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        len_d        = len_q;
        ovf_d        = ovf_q;
        dump_data_d  = dump_data_q;
        dump_ovf_d   = dump_ovf_q;
        dump_valid_d = 1'b0;
        if (ce) begin
            if (clr) begin
                acc_d = '0;
                cnt_d = '0;
                ovf_d = 1'b0;
            end else if (in_valid) begin
                len_d = len_eff;
                if (len_eff == '0) begin
                    acc_d = res;
                    ovf_d = ovf_q | add_ovf;
                end else if (last) begin
                    dump_data_d  = res;
                    dump_ovf_d   = ovf_q | add_ovf;
                    dump_valid_d = 1'b1;
                    acc_d        = '0;
                    cnt_d        = '0;
                    ovf_d        = 1'b0;
                end else begin
                    acc_d = res;
                    cnt_d = cnt_q + CNT_W'(1);
                    ovf_d = ovf_q | add_ovf;
                end
            end
        end
    end

    // State registers; the dump pulse is reloaded every edge regardless of ce.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q        <= '0;
            cnt_q        <= '0;
            len_q        <= '0;
            ovf_q        <= 1'b0;
            dump_data_q  <= '0;
            dump_ovf_q   <= 1'b0;
            dump_valid_q <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            ovf_q        <= ovf_d;
            dump_data_q  <= dump_data_d;
            dump_ovf_q   <= dump_ovf_d;
            dump_valid_q <= dump_valid_d;
        end
    end

    assign Y          = acc_q;
    assign ovf        = ovf_q;
    assign dump_data  = dump_data_q;
    assign dump_ovf   = dump_ovf_q;
    assign dump_valid = dump_valid_q;

endmodule

// File: tb/tb_accumulator_dump.sv
// tb_accumulator_dump: directed vector bench for accumulator_dump.
// Default, wrapping and signed instances share one stimulus stream.
module tb_accumulator_dump;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b0;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic [12:0] a = '0;
    logic [7:0]  dump_len = '0;

    logic [19:0] y0, dd0, y1, dd1, y2, dd2;
    logic        dv0, dovf0, ovf0;
    logic        dv1, dovf1, ovf1;
    logic        dv2, dovf2, ovf2;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    accumulator_dump u_def (
        .clk(clk), .rst(rst), .ce(ce), .clr(clr),
        .in_valid(in_valid), .A(a), .dump_len(dump_len),
        .Y(y0), .dump_data(dd0), .dump_valid(dv0),
        .dump_ovf(dovf0), .ovf(ovf0)
    );

    accumulator_dump #(.SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .ce(ce), .clr(clr),
        .in_valid(in_valid), .A(a), .dump_len(dump_len),
        .Y(y1), .dump_data(dd1), .dump_valid(dv1),
        .dump_ovf(dovf1), .ovf(ovf1)
    );

    accumulator_dump #(.SIGNED(1'b1)) u_sgn (
        .clk(clk), .rst(rst), .ce(ce), .clr(clr),
        .in_valid(in_valid), .A(a), .dump_len(dump_len),
        .Y(y2), .dump_data(dd2), .dump_valid(dv2),
        .dump_ovf(dovf2), .ovf(ovf2)
    );

    typedef struct {
        logic        ce;
        logic        clr;
        logic        iv;
        logic [12:0] a;
        logic [7:0]  len;
        logic [19:0] y;
        logic        dv;
        logic [19:0] dd;
        logic        dovf;
        logic        ovf;
    } vec_t;

    vec_t tbl[27];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, act, act, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        ce = 1'b1;
        clr = 1'b0;
        in_valid = 1'b0;
    endtask

    function automatic vec_t mk(input logic c, input logic cl,
                                input logic iv, input int av,
                                input int len, input int y,
                                input logic dv, input int dd);
        vec_t v;
        v.ce = c;
        v.clr = cl;
        v.iv = iv;
        v.a = 13'(av);
        v.len = 8'(len);
        v.y = 20'(y);
        v.dv = dv;
        v.dd = 20'(dd);
        v.dovf = 1'b0;
        v.ovf = 1'b0;
        return v;
    endfunction

    initial begin
        // Basic 4-sample window
        tbl[0]  = mk(1, 0, 1, 100, 4, 100,  0, 0);
        tbl[1]  = mk(1, 0, 1, 200, 4, 300,  0, 0);
        tbl[2]  = mk(1, 0, 1, 300, 4, 600,  0, 0);
        tbl[3]  = mk(1, 0, 1, 400, 4, 0,    1, 1000);
        tbl[4]  = mk(1, 0, 0, 0,   4, 0,    0, 1000);
        // clr on the 4th sample discards it and the window
        tbl[5]  = mk(1, 0, 1, 10,  4, 10,   0, 1000);
        tbl[6]  = mk(1, 0, 1, 10,  4, 20,   0, 1000);
        tbl[7]  = mk(1, 0, 1, 10,  4, 30,   0, 1000);
        tbl[8]  = mk(1, 1, 1, 10,  4, 0,    0, 1000);
        tbl[9]  = mk(1, 0, 1, 5,   4, 5,    0, 1000);
        tbl[10] = mk(1, 0, 1, 5,   4, 10,   0, 1000);
        tbl[11] = mk(1, 0, 1, 5,   4, 15,   0, 1000);
        tbl[12] = mk(1, 0, 1, 5,   4, 0,    1, 20);
        tbl[13] = mk(1, 0, 0, 0,   4, 0,    0, 20);
        // ce low freezes; mid-window length change waits for next window
        tbl[14] = mk(1, 0, 1, 7,   4, 7,    0, 20);
        tbl[15] = mk(1, 0, 1, 7,   2, 14,   0, 20);
        tbl[16] = mk(0, 0, 1, 9,   2, 14,   0, 20);
        tbl[17] = mk(0, 0, 1, 9,   2, 14,   0, 20);
        tbl[18] = mk(0, 0, 1, 9,   2, 14,   0, 20);
        tbl[19] = mk(0, 0, 1, 9,   2, 14,   0, 20);
        tbl[20] = mk(0, 0, 1, 9,   2, 14,   0, 20);
        tbl[21] = mk(1, 0, 1, 7,   2, 21,   0, 20);
        tbl[22] = mk(1, 0, 1, 7,   2, 0,    1, 28);
        tbl[23] = mk(0, 0, 0, 0,   2, 0,    0, 28);
        tbl[24] = mk(1, 0, 1, 1,   2, 1,    0, 28);
        tbl[25] = mk(1, 0, 1, 1,   2, 0,    1, 2);
        tbl[26] = mk(1, 0, 0, 0,   2, 0,    0, 2);

        #2;
        chk("rst_y", 32'(y0), 0);
        chk("rst_dv", 32'(dv0), 0);
        chk("rst_dd", 32'(dd0), 0);
        chk("rst_ovf", 32'(ovf0), 0);
        chk("rst_dovf", 32'(dovf0), 0);

        do_reset();
        for (int i = 0; i < 27; i++) begin
            ce = tbl[i].ce;
            clr = tbl[i].clr;
            in_valid = tbl[i].iv;
            a = tbl[i].a;
            dump_len = tbl[i].len;
            step();
            chk($sformatf("v%0d_y", i), 32'(y0), 32'(tbl[i].y));
            chk($sformatf("v%0d_dv", i), 32'(dv0), 32'(tbl[i].dv));
            chk($sformatf("v%0d_dd", i), 32'(dd0), 32'(tbl[i].dd));
            chk($sformatf("v%0d_dovf", i), 32'(dovf0), 32'(tbl[i].dovf));
            chk($sformatf("v%0d_ovf", i), 32'(ovf0), 32'(tbl[i].ovf));
        end

        // Async reset between edges with accumulator at 500
        ce = 1'b1;
        in_valid = 1'b1;
        a = 13'd500;
        dump_len = 8'd0;
        step();
        in_valid = 1'b0;
        chk("pre_rst_y", 32'(y0), 500);
        chk("pre_rst_dd", 32'(dd0), 2);
        #3;
        rst = 1'b1;
        #1;
        chk("async_y", 32'(y0), 0);
        chk("async_dd", 32'(dd0), 0);
        chk("async_dv", 32'(dv0), 0);
        chk("async_ovf", 32'(ovf0), 0);
        chk("async_dovf", 32'(dovf0), 0);
        rst = 1'b0;

        // Free-running 8191 * 128 = 1048448, then one more overflows
        do_reset();
        dump_len = 8'd0;
        in_valid = 1'b1;
        a = 13'd8191;
        for (int i = 0; i < 128; i++) begin
            step();
        end
        chk("fr_sat_y", 32'(y0), 1048448);
        chk("fr_sat_ovf", 32'(ovf0), 0);
        chk("fr_wrap_y", 32'(y1), 1048448);
        chk("fr_wrap_ovf", 32'(ovf1), 0);
        step();
        in_valid = 1'b0;
        chk("sat_y", 32'(y0), 1048575);
        chk("sat_ovf", 32'(ovf0), 1);
        chk("sat_dv", 32'(dv0), 0);
        // 8191 * 129 = 1056639, minus 2^20 = 8063
        chk("wrap_y", 32'(y1), 8063);
        chk("wrap_ovf", 32'(ovf1), 1);
        chk("wrap_dv", 32'(dv1), 0);
        step();
        chk("sat_hold_y", 32'(y0), 1048575);
        chk("sat_hold_ovf", 32'(ovf0), 1);

        // Signed window of three -1 samples
        do_reset();
        dump_len = 8'd3;
        in_valid = 1'b1;
        a = 13'h1FFF;
        step();
        chk("sgn_y1", 32'(y2), 32'h000F_FFFF);
        step();
        chk("sgn_y2", 32'(y2), 32'h000F_FFFE);
        step();
        in_valid = 1'b0;
        chk("sgn_dd", 32'(dd2), 32'h000F_FFFD);
        chk("sgn_dv", 32'(dv2), 1);
        chk("sgn_dovf", 32'(dovf2), 0);
        chk("sgn_y3", 32'(y2), 0);
        chk("uns_dd", 32'(dd0), 24573);
        step();
        chk("sgn_dv_off", 32'(dv2), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
